hazard_unit: RTL

- Pipeline hazard controller for the 5-stage ARM pipelined core. It is the counterpart of the datapath's hazard interface.
- Consumes the datapath's register-match flags and the decode-stage control bits. Tracks RegWrite, MemtoReg and PCSrc through its own E/M/W shadow registers.
- Drives the forwarding selects (FowardAE/FowardBE) and the StallF, StallD, FlushD and FlushE controls back into the datapath.
- Keeps saturating stall and flush event counters for performance debug.

---
 rtl/hazard_unit_if.sv | 32 +++
 rtl/hazard_unit.sv | 98 +++++++++
 2 files changed

// File: rtl/hazard_unit_if.sv
// hazard_unit_if: hazard-control bundle between the pipelined datapath and the
// hazard unit. The master side is the hazard unit, which consumes match flags
// and decode-stage control bits and returns forwarding/stall/flush controls.
interface hazard_unit_if #(
  parameter int CNT_W = 16
);
  logic             Enable;
  logic [3:0]       Match;
  logic [1:0]       MatchLdD;
  logic             RegWriteD;
  logic             MemtoRegD;
  logic             PCSrcD;
  logic             BranchtakenE;
  logic [1:0]       FowardAE;
  logic [1:0]       FowardBE;
  logic             StallF;
  logic             StallD;
  logic             FlushD;
  logic             FlushE;
  logic [CNT_W-1:0] StallCount;
  logic [CNT_W-1:0] FlushCount;

  modport master (
    input  Enable, Match, MatchLdD, RegWriteD, MemtoRegD, PCSrcD, BranchtakenE,
    output FowardAE, FowardBE, StallF, StallD, FlushD, FlushE, StallCount, FlushCount
  );

  modport slave (
    output Enable, Match, MatchLdD, RegWriteD, MemtoRegD, PCSrcD, BranchtakenE,
    input  FowardAE, FowardBE, StallF, StallD, FlushD, FlushE, StallCount, FlushCount
  );
endinterface

// File: rtl/hazard_unit.sv
// hazard_unit: pipeline hazard controller for the 5-stage ARM core. Shadows
// RegWrite/MemtoReg/PCSrc through E/M/W, selects operand forwarding, detects
// load-use and R15-write hazards, and counts stall/flush events (saturating).
module hazard_unit #(
  parameter int CNT_W = 16
) (
  input  logic          clk,
  input  logic          reset,
  hazard_unit_if.master hz
);

  localparam logic [CNT_W-1:0] CntMax = '1;
  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  logic             r_regWriteE;
  logic             r_memtoRegE;
  logic             r_pcSrcE;
  logic             r_regWriteM;
  logic             r_pcSrcM;
  logic             r_regWriteW;
  logic             r_pcSrcW;
  logic [CNT_W-1:0] r_stallCount;
  logic [CNT_W-1:0] r_flushCount;

  logic             w_ldrStall;
  logic             w_pcWrPend;
  logic             w_flushE;
  logic [1:0]       w_fowardAE;
  logic [1:0]       w_fowardBE;

  // Hazard detection and forwarding selects; memory stage beats writeback
  always_comb begin
    w_ldrStall = r_memtoRegE & r_regWriteE & (hz.MatchLdD[0] | hz.MatchLdD[1]);
    w_pcWrPend = hz.PCSrcD | r_pcSrcE | r_pcSrcM;
    w_flushE   = w_ldrStall | hz.BranchtakenE;

    w_fowardAE = 2'b00;
    if (hz.Match[0] && r_regWriteM) begin
      w_fowardAE = 2'b10;
    end else if (hz.Match[1] && r_regWriteW) begin
      w_fowardAE = 2'b01;
    end

    w_fowardBE = 2'b00;
    if (hz.Match[2] && r_regWriteM) begin
      w_fowardBE = 2'b10;
    end else if (hz.Match[3] && r_regWriteW) begin
      w_fowardBE = 2'b01;
    end
  end

  assign hz.FowardAE   = w_fowardAE;
  assign hz.FowardBE   = w_fowardBE;
  assign hz.StallF     = w_ldrStall | w_pcWrPend;
  assign hz.StallD     = w_ldrStall;
  assign hz.FlushD     = w_pcWrPend | r_pcSrcW | hz.BranchtakenE;
  assign hz.FlushE     = w_flushE;
  assign hz.StallCount = r_stallCount;
  assign hz.FlushCount = r_flushCount;

  // Shadow control pipeline; a flushed E stage becomes a bubble and a taken
  // branch cancels the R15 write of the instruction it resolves in execute
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_regWriteE <= 1'b0;
      r_memtoRegE <= 1'b0;
      r_pcSrcE    <= 1'b0;
      r_regWriteM <= 1'b0;
      r_pcSrcM    <= 1'b0;
      r_regWriteW <= 1'b0;
      r_pcSrcW    <= 1'b0;
    end else if (hz.Enable) begin
      r_regWriteE <= w_flushE ? 1'b0 : hz.RegWriteD;
      r_memtoRegE <= w_flushE ? 1'b0 : hz.MemtoRegD;
      r_pcSrcE    <= w_flushE ? 1'b0 : hz.PCSrcD;
      r_regWriteM <= r_regWriteE;
      r_pcSrcM    <= r_pcSrcE & ~hz.BranchtakenE;
      r_regWriteW <= r_regWriteM;
      r_pcSrcW    <= r_pcSrcM;
    end
  end

  // Saturating event counters for load-use stalls and taken-branch flushes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stallCount <= '0;
      r_flushCount <= '0;
    end else if (hz.Enable) begin
      if (w_ldrStall && (r_stallCount != CntMax)) begin
        r_stallCount <= r_stallCount + CntOne;
      end
      if (hz.BranchtakenE && (r_flushCount != CntMax)) begin
        r_flushCount <= r_flushCount + CntOne;
      end
    end
  end

endmodule
